// File: rtl/operand_entry_fsm_if.sv
// rtl/operand_entry_fsm_if.sv - operand entry key/switch inputs and ALU operand outputs
//
// Purpose: bundles the raw front-panel inputs and the latched ALU-side outputs
//          of operand_entry_fsm.
// Signals: key_n[1:0] raw active-low buttons (0 = ENTER, 1 = BANK)
//          sw[9:0]    slide switches (7:0 operand data, 9:8 op-select low bits)
//          opA/opB    latched operands, S registered op select,
//          phase      FSM state code, start one-cycle "operands ready" pulse
// Modports: master drives the inputs (panel side), slave is the FSM.

interface operand_entry_fsm_if;
  logic [1:0] key_n;
  logic [9:0] sw;
  logic [7:0] opA;
  logic [7:0] opB;
  logic [3:0] S;
  logic [1:0] phase;
  logic       start;

  modport master (output key_n, sw, input opA, opB, S, phase, start);
  modport slave  (input key_n, sw, output opA, opB, S, phase, start);
endinterface

// File: rtl/operand_entry_fsm.sv
// rtl/operand_entry_fsm.sv - debounced two-key operand entry FSM for an ALU front panel
//
// Purpose: synchronizes and debounces ENTER/BANK keys, sequences operand entry
//          LOAD_A -> LOAD_B -> RUN, and drives the registered op select S.
// Ports:   clk      system clock, all state on rising edge
//          reset_n  synchronous active-low reset
//          bus      operand_entry_fsm_if.slave (key_n, sw in; opA, opB, S, phase, start out)

module operand_entry_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  operand_entry_fsm_if.slave    bus
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    RUN    = 2'b10,
    UNUSED = 2'b11
  } phase_e;

  logic [1:0]         meta_q;
  logic [1:0]         sync_q;
  logic [1:0]         stable_q;
  logic [1:0]         press_q;
  logic [1:0][CW-1:0] cnt_q;

  phase_e     phase_q;
  logic [7:0] opa_q;
  logic [7:0] opb_q;
  logic [1:0] bank_q;
  logic [3:0] s_q;
  logic       start_q;

  logic enter_ev;
  logic bank_ev;

  // Synchronizer and per-key debounce. The counter only runs while the
  // synchronized level disagrees with the stable level; the press pulse is
  // raised on the same edge the stable level falls, so the FSM acts one
  // cycle later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q   <= 2'b11;
      sync_q   <= 2'b11;
      stable_q <= 2'b11;
      press_q  <= 2'b00;
      cnt_q    <= '0;
    end else begin
      meta_q  <= bus.key_n;
      sync_q  <= meta_q;
      press_q <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        if (sync_q[k] == stable_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == CNT_LAST) begin
          cnt_q[k]    <= '0;
          stable_q[k] <= sync_q[k];
          // Only a 1->0 transition of the stable level is a press.
          press_q[k]  <= stable_q[k];
        end else begin
          cnt_q[k] <= cnt_q[k] + CW'(1);
        end
      end
    end
  end

  assign enter_ev = press_q[0];
  assign bank_ev  = press_q[1];

  // Operand entry FSM with registered outputs. S reflects the state held
  // before the edge, so it blanks for one cycle on entering RUN and shows
  // the bank/sw code for one cycle after leaving it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q <= LOAD_A;
      opa_q   <= 8'h00;
      opb_q   <= 8'h00;
      bank_q  <= 2'b00;
      s_q     <= 4'b1111;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      s_q     <= 4'b1111;
      case (phase_q)
        LOAD_A: begin
          if (enter_ev) begin
            opa_q   <= bus.sw[7:0];
            phase_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (enter_ev) begin
            opb_q   <= bus.sw[7:0];
            phase_q <= RUN;
            start_q <= 1'b1;
          end
        end
        RUN: begin
          s_q <= {bank_q, bus.sw[9:8]};
          // ENTER wins over a coincident BANK press.
          if (enter_ev) begin
            phase_q <= LOAD_A;
          end else if (bank_ev) begin
            bank_q <= bank_q + 2'd1;
          end
        end
        default: begin
          phase_q <= LOAD_A;
        end
      endcase
    end
  end

  assign bus.opA   = opa_q;
  assign bus.opB   = opb_q;
  assign bus.S     = s_q;
  assign bus.phase = phase_q;
  assign bus.start = start_q;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// tb/tb_operand_entry_fsm.sv - self-checking bench for operand_entry_fsm

module tb_operand_entry_fsm;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  operand_entry_fsm_if bus();

  operand_entry_fsm #(.DEBOUNCE_CYCLES(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Key handling: a key's stable level flips once the last
  // N synchronized samples (raw samples delayed by two clocks) all disagree
  // with it; a fall of the stable level is a press acted on next clock.
  bit         m_valid = 0;
  int         m_ph;
  logic [7:0] m_a, m_b;
  logic [1:0] m_bank;
  logic [3:0] m_s;
  logic       m_start;
  logic [1:0] m_stable, m_pend, m_ev;
  logic [1:0] hist [N+2];
  bit         all_diff;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_valid = 1;
      m_ph = 0; m_a = 8'h00; m_b = 8'h00; m_bank = 2'b00;
      m_s = 4'hF; m_start = 1'b0; m_stable = 2'b11; m_pend = 2'b00;
      for (int i = 0; i < N + 2; i++) hist[i] = 2'b11;
    end else if (m_valid) begin
      m_ev    = m_pend;
      m_s     = (m_ph == 2) ? {m_bank, bus.sw[9:8]} : 4'hF;
      m_start = 1'b0;
      if (m_ev[0]) begin
        if (m_ph == 0) begin m_a = bus.sw[7:0]; m_ph = 1; end
        else if (m_ph == 1) begin m_b = bus.sw[7:0]; m_ph = 2; m_start = 1'b1; end
        else m_ph = 0;
      end else if (m_ev[1] && m_ph == 2) begin
        m_bank = m_bank + 2'd1;
      end
      for (int i = N + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = bus.key_n;
      m_pend = 2'b00;
      for (int k = 0; k < 2; k++) begin
        all_diff = 1;
        for (int j = 2; j < N + 2; j++) if (hist[j][k] == m_stable[k]) all_diff = 0;
        if (all_diff) begin
          m_pend[k]   = m_stable[k];
          m_stable[k] = ~m_stable[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("phase", 32'(bus.phase), 32'(m_ph));
      check("opA", 32'(bus.opA), 32'(m_a));
      check("opB", 32'(bus.opB), 32'(m_b));
      check("S", 32'(bus.S), 32'(m_s));
      check("start", 32'(bus.start), 32'(m_start));
      if (bus.start === 1'b1) start_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k, input int low, input int high);
    bus.key_n[k] = 1'b0;
    tick(low);
    bus.key_n[k] = 1'b1;
    tick(high);
  endtask

  logic [3:0] exp_s [4];

  initial begin
    bus.key_n = 2'b11;
    bus.sw    = 10'h000;
    reset_n   = 1'b0;
    tick(3);
    check("rst_phase", 32'(bus.phase), 32'h0);
    check("rst_S", 32'(bus.S), 32'hF);
    check("rst_opA", 32'(bus.opA), 32'h0);
    check("rst_start", 32'(bus.start), 32'h0);
    reset_n = 1'b1;
    tick(2);

    // Basic entry sequence.
    bus.sw = 10'h035;
    press(0, 10, 10);
    bus.sw = 10'h00A;
    press(0, 10, 10);
    check("seq_opA", 32'(bus.opA), 32'h35);
    check("seq_opB", 32'(bus.opB), 32'h0A);
    check("seq_phase", 32'(bus.phase), 32'h2);
    check("seq_start_cnt", 32'(start_cnt), 32'd1);
    check("seq_S", 32'(bus.S), 32'h0);
    bus.sw[9:8] = 2'b11;
    tick(2);
    check("seq_S_track", 32'(bus.S), 32'h3);

    // BANK wrap in RUN.
    bus.sw[9:8] = 2'b10;
    exp_s[0] = 4'b0110; exp_s[1] = 4'b1010; exp_s[2] = 4'b1110; exp_s[3] = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      press(1, 10, 10);
      check("bank_S", 32'(bus.S), 32'(exp_s[i]));
    end

    // Leave RUN.
    press(0, 10, 10);
    check("exit_phase", 32'(bus.phase), 32'h0);
    check("exit_S", 32'(bus.S), 32'hF);
    check("exit_opA", 32'(bus.opA), 32'h35);
    check("exit_opB", 32'(bus.opB), 32'h0A);

    // Bouncing ENTER gives exactly one event.
    bus.sw = 10'h077;
    for (int i = 0; i < 5; i++) begin
      bus.key_n[0] = 1'b0; tick(3);
      bus.key_n[0] = 1'b1; tick(1);
    end
    press(0, 10, 10);
    check("bounce_phase", 32'(bus.phase), 32'h1);
    check("bounce_opA", 32'(bus.opA), 32'h77);

    // BANK ignored in LOAD_B; ENTER+BANK together latches opB only.
    press(1, 10, 10);
    check("ldb_bank_phase", 32'(bus.phase), 32'h1);
    bus.sw = 10'h0C3;
    bus.key_n = 2'b00; tick(10);
    bus.key_n = 2'b11; tick(10);
    check("both_phase", 32'(bus.phase), 32'h2);
    check("both_opB", 32'(bus.opB), 32'hC3);
    check("both_S", 32'(bus.S), 32'h0);

    // Reset with BANK mid-debounce: no event survives, bank cleared.
    press(1, 10, 10);
    check("pre_rst_S", 32'(bus.S), 32'h4);
    bus.key_n[1] = 1'b0;
    tick(4);
    reset_n = 1'b0;
    bus.key_n[1] = 1'b1;
    tick(1);
    reset_n = 1'b1;
    check("mid_rst_phase", 32'(bus.phase), 32'h0);
    check("mid_rst_opA", 32'(bus.opA), 32'h0);
    check("mid_rst_opB", 32'(bus.opB), 32'h0);
    check("mid_rst_S", 32'(bus.S), 32'hF);
    tick(20);
    bus.sw = 10'h000;
    press(0, 10, 10);
    press(0, 10, 10);
    check("post_rst_bank_S", 32'(bus.S), 32'h0);

    // ENTER held through reset release acts once in LOAD_A.
    bus.sw = 10'h1E5;
    bus.key_n[0] = 1'b0;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(12);
    bus.key_n[0] = 1'b1;
    tick(10);
    check("held_phase", 32'(bus.phase), 32'h1);
    check("held_opA", 32'(bus.opA), 32'hE5);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) bus.key_n[0] = ~bus.key_n[0];
      if ($urandom_range(0, 5) == 0) bus.key_n[1] = ~bus.key_n[1];
      if ($urandom_range(0, 19) == 0) bus.sw = 10'($urandom);
      reset_n = ($urandom_range(0, 599) != 0);
      tick(1);
    end
    reset_n = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
